// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access codes,
// FSM states and the access-legality check used when a request is launched.
package lsu_mem_stage_pkg;

   localparam int LSU_DATA_WIDTH = 32;
   localparam int STRB_WIDTH     = LSU_DATA_WIDTH / 8;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RSP  = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_t;

   // Stores only accept B/H/W; loads add the unsigned variants.
   function automatic logic access_fault(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
      logic legal;
      logic misaligned;
      if (is_store)
         legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
      misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                   ((funct3[1:0] == 2'b10) && (off != 2'b00));
      return !legal || misaligned;
   endfunction

endpackage

// File: rtl/lsu_mem_stage_load_extend.sv
// Combinational load-data aligner: shifts the addressed byte/halfword down
// and sign- or zero-extends it according to funct3.
module lsu_mem_stage_load_extend
   import lsu_mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] raw,
   input  logic [1:0]            off,
   input  logic [2:0]            funct3,
   output logic [DATA_WIDTH-1:0] rdata_next
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted = raw >> {off, 3'b000};
      case (funct3)
         F3_B:    rdata_next = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         F3_H:    rdata_next = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         F3_BU:   rdata_next = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
         F3_HU:   rdata_next = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
         // Word loads are always aligned, so the shift is a no-op here.
         default: rdata_next = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage LSU: one dmem access at a time; holds the request until ready, stalls
// the pipeline until done (zero-wait: load 3 / store 2 stall cycles, then a DONE cycle).
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH = LSU_DATA_WIDTH,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            mem_funct3,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata_in,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [STRB_WIDTH-1:0] dmem_wstrb,
   input  logic                  dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  lsu_stall,
   output logic                  lsu_fault
);

   lsu_state_t            state;
   logic                  busy;
   logic [1:0]            off_q;
   logic [2:0]            funct3_q;
   logic                  start;
   logic                  fault;
   logic [DATA_WIDTH-1:0] lane_wdata;
   logic [STRB_WIDTH-1:0] lane_wstrb;
   logic [DATA_WIDTH-1:0] rdata_next;

   assign start     = mem_valid & (mem_read | mem_write);
   assign fault     = access_fault(mem_write, mem_funct3, mem_addr[1:0]);
   assign lsu_fault = (state == LSU_IDLE) & start & fault;
   assign lsu_stall = (state == LSU_IDLE) ? (start & ~fault) : busy;

   always_comb begin
      case (mem_funct3[1:0])
         2'b00: begin
            lane_wstrb = STRB_WIDTH'(1) << mem_addr[1:0];
            lane_wdata = {(DATA_WIDTH/8){mem_wdata_in[7:0]}};
         end
         2'b01: begin
            lane_wstrb = STRB_WIDTH'(3) << mem_addr[1:0];
            lane_wdata = {(DATA_WIDTH/16){mem_wdata_in[15:0]}};
         end
         default: begin
            lane_wstrb = {STRB_WIDTH{1'b1}};
            lane_wdata = mem_wdata_in;
         end
      endcase
   end

   lsu_mem_stage_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .raw        (dmem_rsp_rdata),
      .off        (off_q),
      .funct3     (funct3_q),
      .rdata_next (rdata_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= LSU_IDLE;
         busy           <= 1'b0;
         off_q          <= 2'b00;
         funct3_q       <= 3'b000;
         dmem_req_valid <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_wdata     <= '0;
         dmem_wstrb     <= '0;
         mem_rdata      <= '0;
      end else begin
         case (state)
            LSU_IDLE: begin
               if (start && !fault) begin
                  off_q          <= mem_addr[1:0];
                  funct3_q       <= mem_funct3;
                  dmem_we        <= mem_write;
                  dmem_addr      <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                  dmem_wdata     <= lane_wdata;
                  dmem_wstrb     <= mem_write ? lane_wstrb : '0;
                  dmem_req_valid <= 1'b1;
                  busy           <= 1'b1;
                  state          <= LSU_REQ;
               end
            end
            LSU_REQ: begin
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  if (dmem_we) begin
                     busy  <= 1'b0;
                     state <= LSU_DONE;
                  end else begin
                     state <= LSU_RSP;
                  end
               end
            end
            LSU_RSP: begin
               if (dmem_rsp_valid) begin
                  mem_rdata <= rdata_next;
                  busy      <= 1'b0;
                  state     <= LSU_DONE;
               end
            end
            // The MEM instruction is unchanged in DONE, so it must not relaunch.
            default: state <= LSU_IDLE;
         endcase
      end
   end

endmodule
